// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer in front of DataMemory.
// Sizes, FSM states and the byte-lane width are defined here.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane logic: load extraction/extension, store merge into the
// old word, and the alignment check for a request.
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [LANE_W-1:0]   byte_val;
  logic [2*LANE_W-1:0] half_val;

  always_comb begin
    byte_val = old_word[7:0];
    case (addr_lo)
      2'd0: byte_val = old_word[7:0];
      2'd1: byte_val = old_word[15:8];
      2'd2: byte_val = old_word[23:16];
      2'd3: byte_val = old_word[31:24];
      default: byte_val = old_word[7:0];
    endcase
    half_val = addr_lo[1] ? old_word[31:16] : old_word[15:0];
  end

  always_comb begin
    load_data = old_word;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SIZE_HALF: load_data = is_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default:   load_data = old_word;
    endcase
  end

  // Only the addressed lane(s) are replaced; the rest of the old word survives.
  always_comb begin
    merged_word = old_word;
    case (size)
      SIZE_BYTE: begin
        case (addr_lo)
          2'd0: merged_word[7:0]   = wdata[7:0];
          2'd1: merged_word[15:8]  = wdata[7:0];
          2'd2: merged_word[23:16] = wdata[7:0];
          2'd3: merged_word[31:24] = wdata[7:0];
          default: merged_word = old_word;
        endcase
      end
      SIZE_HALF: begin
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

  assign misaligned = (size == 2'b11)
                   || ((size == SIZE_HALF) && addr_lo[0])
                   || ((size == SIZE_WORD) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer driving a word-addressed DataMemory; sub-word stores are
// done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_read asserted, read word captured at cycle end
// WR    | mem_write asserted for one cycle with the final word
// RESP  | one-cycle resp_valid pulse
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  logic              lat_write;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [1:0]        lat_addr_lo;
  logic [DATA_W-1:0] lat_wdata;

  logic [1:0]        al_addr_lo;
  logic [1:0]        al_size;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;
  logic              misaligned;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign al_addr_lo = (state == IDLE) ? req_addr[1:0] : lat_addr_lo;
  assign al_size    = (state == IDLE) ? req_size      : lat_size;

  load_store_align u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .is_unsigned (lat_unsigned),
    .old_word    (mem_read_data),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      lat_write      <= 1'b0;
      lat_size       <= SIZE_BYTE;
      lat_unsigned   <= 1'b0;
      lat_addr_lo    <= 2'b00;
      lat_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr_lo  <= req_addr[1:0];
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (req_size == SIZE_WORD)) begin
              state          <= WR;
              mem_write      <= 1'b1;
              mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_write_data <= req_wdata;
            end else begin
              state       <= RD;
              mem_read    <= 1'b1;
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (lat_write) begin
            state          <= WR;
            mem_write      <= 1'b1;
            mem_write_data <= merged_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          mem_write  <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer directly upstream of DataMemory, which is word-addressed. Accepts one byte, halfword or word load/store request per transaction from the MEM pipeline stage over a valid/ready handshake. Drives DataMemory's address, write_data, MemRead and MemWrite. Sub-word stores are done as a read-modify-write, and loads are returned sign- or zero-extended.

Parameters:
ADDR_W, 32, request/memory byte-address width
DATA_W, 32, data width; fixed at 32 (the byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_error  out  1  misaligned or illegal size, valid with resp_valid
mem_address  out  ADDR_W  to DataMemory address; always word-aligned (bits [1:0]=0)
mem_write_data  out  DATA_W  to DataMemory write_data
mem_read  out  1  to DataMemory MemRead
mem_write  out  1  to DataMemory MemWrite
mem_read_data  in  DATA_W  from DataMemory read_data

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0; mem_read=0; mem_write=0; mem_address=0; mem_write_data=0. All outputs are registered.
- Reset mid-transaction aborts immediately: mem_write drops asynchronously, no response is issued, and the request is lost.
- Accept when req_valid&&req_ready at posedge. Latch write, size, unsigned, addr, and wdata.
- Alignment check at accept. Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Go straight to RESP with resp_error=1 and resp_rdata=0.
  - No memory access occurs.
- Byte lanes are little-endian: lane = addr[1:0], bits [8*lane+7 : 8*lane]. Halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RD: load, or byte/half store.
  - IDLE -> WR: word store.
  - IDLE -> RESP: error.
  - RD: mem_read=1, mem_address={addr[31:2],2'b00}. At the end of the cycle, capture mem_read_data (memory read is combinational within one cycle).
    - Load: RD -> RESP.
    - Sub-word store: RD -> WR.
  - WR: mem_write=1 for exactly one cycle, mem_write_data = merged word.
    - Merged word: captured word with the target lane(s) replaced by req_wdata[7:0] or [15:0].
    - Word store writes req_wdata unmodified.
    - DataMemory commits on the negedge inside WR.
    - WR -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- Load data: the selected lane is extracted and extended per req_unsigned. Word loads ignore req_unsigned.
- Latency from accept edge to resp_valid high:
  - word/byte/half load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- No response backpressure; resp_valid is a single-cycle pulse. req_ready=0 in RD, WR and RESP. The next accept is possible on the first IDLE cycle after RESP.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- req_* inputs are ignored while req_ready=0.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - FSM state enum: IDLE, RD, WR, RESP
  - lane width constant: 8
- One sub-module, load_store_align (purely combinational). Given addr[1:0], size, unsigned, old word and wdata, it produces:
  - the extended load value
  - the merged store word
  - the misaligned flag
- The top level holds the FSM and registers.

Test Plan:
- Word load: mem word 1 = 0x8081_7F01; load word addr 0x4 -> resp_valid 2 cycles after accept, rdata=0x8081_7F01, error=0, exactly one mem_read cycle.
- Byte loads, same word:
  - signed addr 0x7 -> 0xFFFF_FF80
  - unsigned addr 0x7 -> 0x0000_0080
  - signed addr 0x5 -> 0x0000_007F
- Halfword store: wdata 0x0000_BEEF to addr 0x6 -> sequence RD, WR, RESP; mem_write_data=0xBEEF_7F01, mem_address=0x4; a subsequent word load returns 0xBEEF_7F01.
- Misaligned: word load addr 0x2 and half store addr 0x5 -> resp_error=1 after 1 cycle, rdata=0, mem_read and mem_write never asserted, memory unchanged.
- Back-to-back: hold req_valid with word store 0x1234_5678 to 0x8, then word load 0x8. Checks:
  - req_ready low during busy
  - second accept on the IDLE cycle after RESP
  - load returns 0x1234_5678
- Reset during WR: assert rst_n low mid-WR -> mem_write=0 immediately, resp_valid never pulses, req_ready=1 after release, a following word load works.
